frame_write_bridge: RTL and testbench

FRAME_WRITE_BRIDGE -- requirements
Module: frame_write_bridge

---
 rtl/frame_write_bridge.sv | 182 ++++++++++++++++++
 tb/tb_frame_write_bridge.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_write_bridge.sv
// frame_write_bridge: buffers pixel words from a pattern source in a show-ahead
// FIFO and hands them to an SDRAM controller as fixed-length write bursts,
// walking the burst address through one frame and wrapping at the frame end.
// Optional build macro: OVERFLOW_STICKY_EN -- when defined, overflow holds
// from the first dropped word until reset; otherwise it pulses once per drop.
module frame_write_bridge #(
  parameter int DATA_W      = 24,
  parameter int FIFO_DEPTH  = 512,
  parameter int BURST_LEN   = 256,
  parameter int FRAME_WORDS = 307200,
  parameter int ADDR_W      = 24
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          init_done,
  output logic                          sys_vaild,
  input  logic                          sys_we,
  input  logic [DATA_W-1:0]             sys_data,
  output logic                          wr_req,
  input  logic                          wr_ack,
  output logic [ADDR_W-1:0]             wr_addr,
  input  logic                          wr_data_en,
  output logic [DATA_W-1:0]             wr_data,
  output logic                          frame_done,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int BCNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  localparam logic [LVL_W-1:0]  LVL_FULL   = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0]  LVL_BURST  = LVL_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] ADDR_INC   = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] ADDR_FRAME = ADDR_W'(FRAME_WORDS);
  localparam logic [BCNT_W-1:0] BCNT_LAST  = BCNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  // FIFO storage and bookkeeping
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W-1:0]  wr_ptr_d, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              overflow_q, overflow_d;
  logic              fifo_full, fifo_empty;
  logic              push, pop, drop;

  // Burst control
  state_t            state_q;
  logic              wr_req_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [ADDR_W-1:0] addr_next;
  logic [BCNT_W-1:0] bcnt_q;
  logic              frame_done_q;
  logic              sys_vaild_q;

  // Push/pop qualification, next occupancy and overflow flag.
  always_comb begin
    // NOTE: every signal gets a default first so no path through this block
    // leaves one unassigned -- otherwise synthesis infers a latch.
    fifo_full  = (level_q == LVL_FULL);
    fifo_empty = (level_q == '0);
    // Pops are honoured only inside a burst and only when a word exists.
    pop        = wr_data_en && (state_q == ST_BURST) && !fifo_empty;
    // A full FIFO still accepts a word when the same cycle frees a slot.
    push       = sys_we && (!fifo_full || pop);
    drop       = sys_we && !push;
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d    = level_q;
    if (push && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop && !push) begin
      level_d = level_q - LVL_W'(1);
    end
`ifdef OVERFLOW_STICKY_EN
    overflow_d = overflow_q | drop;
`else
    overflow_d = drop;
`endif
    addr_next  = wr_addr_q + ADDR_INC;
  end

  // Word storage; written on accepted pushes only.
  always_ff @(posedge clk) begin
    // NOTE: the data array is deliberately not reset -- occupancy and pointers
    // define validity, and leaving the array out of reset lets it map to RAM.
    if (push) begin
      mem_q[wr_ptr_q] <= sys_data;
    end
  end

  // FIFO pointers, occupancy and overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Registered copy of the controller's init status gates new bursts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sys_vaild_q <= 1'b0;
    end else begin
      sys_vaild_q <= init_done;
    end
  end

  // Burst sequencer: wait for a burst's worth of data, request, stream, advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wr_req_q     <= 1'b0;
      wr_addr_q    <= '0;
      bcnt_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if ((level_q >= LVL_BURST) && sys_vaild_q) begin
            state_q  <= ST_REQ;
            wr_req_q <= 1'b1;
          end
        end
        ST_REQ: begin
          // Once requested, the burst runs to completion even if init drops.
          if (wr_ack) begin
            state_q  <= ST_BURST;
            wr_req_q <= 1'b0;
            bcnt_q   <= '0;
          end
        end
        ST_BURST: begin
          if (pop) begin
            if (bcnt_q == BCNT_LAST) begin
              state_q <= ST_IDLE;
              if (addr_next == ADDR_FRAME) begin
                wr_addr_q    <= '0;
                frame_done_q <= 1'b1;
              end else begin
                wr_addr_q <= addr_next;
              end
            end else begin
              bcnt_q <= bcnt_q + BCNT_W'(1);
            end
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          wr_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign sys_vaild  = sys_vaild_q;
  assign wr_req     = wr_req_q;
  assign wr_addr    = wr_addr_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign fill_level = level_q;
  // Show-ahead head word; reads as zero while nothing is buffered.
  assign wr_data    = fifo_empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_frame_write_bridge.sv
// tb_frame_write_bridge: directed scenarios followed by random traffic. A
// queue-based reference model tracks buffered words, burst progress, frame
// address and flags; a negedge monitor compares every DUT output against it
// and scores each consumed word against the head of the expected-word queue.
module tb_frame_write_bridge;

  localparam int DATA_W      = 24;
  localparam int FIFO_DEPTH  = 8;
  localparam int BURST_LEN   = 4;
  localparam int FRAME_WORDS = 8;
  localparam int ADDR_W      = 24;
  localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1;

`ifdef OVERFLOW_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              init_done;
  logic              sys_vaild;
  logic              sys_we;
  logic [DATA_W-1:0] sys_data;
  logic              wr_req;
  logic              wr_ack;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_data_en;
  logic [DATA_W-1:0] wr_data;
  logic              frame_done;
  logic              overflow;
  logic [LVL_W-1:0]  fill_level;

  frame_write_bridge #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .BURST_LEN  (BURST_LEN),
    .FRAME_WORDS(FRAME_WORDS),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_done (init_done),
    .sys_vaild (sys_vaild),
    .sys_we    (sys_we),
    .sys_data  (sys_data),
    .wr_req    (wr_req),
    .wr_ack    (wr_ack),
    .wr_addr   (wr_addr),
    .wr_data_en(wr_data_en),
    .wr_data   (wr_data),
    .frame_done(frame_done),
    .overflow  (overflow),
    .fill_level(fill_level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int frame_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] m_q[$];      // words buffered, oldest first
  bit m_vaild;                    // expected sys_vaild
  bit m_req;                      // a request is outstanding
  bit m_burst;                    // a granted burst is streaming
  int m_left;                     // words still owed to the current burst
  int m_addr;                     // next burst start address
  bit m_fd;                       // expected frame_done
  bit m_ovf;                      // expected overflow

  task automatic model_reset();
    m_q.delete();
    m_vaild = 0; m_req = 0; m_burst = 0; m_left = 0;
    m_addr = 0; m_fd = 0; m_ovf = 0;
  endtask

  task automatic compare_outputs();
    logic [DATA_W-1:0] head;
    head = (m_q.size() > 0) ? m_q[0] : '0;
    check("wr_req",     32'(wr_req),     32'(m_req));
    check("wr_addr",    32'(wr_addr),    32'(m_addr));
    check("frame_done", 32'(frame_done), 32'(m_fd));
    check("overflow",   32'(overflow),   32'(m_ovf));
    check("sys_vaild",  32'(sys_vaild),  32'(m_vaild));
    check("fill_level", 32'(fill_level), 32'(m_q.size()));
    check("wr_data",    32'(wr_data),    32'(head));
  endtask

  // Predict the effect of the coming rising edge from the inputs now applied.
  task automatic model_advance();
    int sz;
    bit do_pop, do_push, do_drop;
    sz      = m_q.size();
    do_pop  = m_burst && wr_data_en && (sz > 0);
    do_push = sys_we && ((sz < FIFO_DEPTH) || do_pop);
    do_drop = sys_we && !do_push;
    if (do_pop) begin
      check("pop_data", 32'(wr_data), 32'(m_q[0]));
      void'(m_q.pop_front());
    end
    if (do_push) m_q.push_back(sys_data);
    m_fd = 0;
    if (m_req) begin
      if (wr_ack) begin
        m_req = 0; m_burst = 1; m_left = BURST_LEN;
      end
    end else if (m_burst) begin
      if (do_pop) begin
        m_left--;
        if (m_left == 0) begin
          m_burst = 0;
          m_addr  = m_addr + BURST_LEN;
          if (m_addr == FRAME_WORDS) begin
            m_addr = 0; m_fd = 1;
          end
        end
      end
    end else if ((sz >= BURST_LEN) && m_vaild) begin
      m_req = 1;
    end
    m_ovf   = STICKY ? (m_ovf | do_drop) : do_drop;
    m_vaild = init_done;
  endtask

  // Monitor: outputs are compared half a cycle after each rising edge.
  always @(negedge clk) begin
    if (!rst_n) model_reset();
    compare_outputs();
    if (frame_done === 1'b1) frame_cnt++;
    if (rst_n) model_advance();
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit we, input logic [DATA_W-1:0] d, input bit den, input bit ack);
    sys_we = we; sys_data = d; wr_data_en = den; wr_ack = ack;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0);
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic do_reset();
    sys_we = 0; wr_data_en = 0; wr_ack = 0;
    rst_n = 0;
    #1;
    check("rst_wr_req",     32'(wr_req),     32'(0));
    check("rst_fill",       32'(fill_level), 32'(0));
    check("rst_wr_addr",    32'(wr_addr),    32'(0));
    check("rst_wr_data",    32'(wr_data),    32'(0));
    check("rst_frame_done", 32'(frame_done), 32'(0));
    check("rst_overflow",   32'(overflow),   32'(0));
    check("rst_sys_vaild",  32'(sys_vaild),  32'(0));
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  initial begin
    int fc0;
    rst_n = 0; init_done = 0; sys_we = 0; sys_data = '0; wr_data_en = 0; wr_ack = 0;
    @(posedge clk); #1;
    check("init_fill",   32'(fill_level), 32'(0));
    check("init_wr_req", 32'(wr_req),     32'(0));
    rst_n = 1; init_done = 1;
    idle(2);
    check("vaild_up", 32'(sys_vaild), 32'(1));

    // First burst: words 1..4 at address 0.
    fc0 = frame_cnt;
    for (int i = 1; i <= 4; i++) step(1, DATA_W'(i), 0, 0);
    check("b1_fill",       32'(fill_level), 32'(4));
    check("b1_req_early",  32'(wr_req),     32'(0));
    idle(1);
    check("b1_req",        32'(wr_req),     32'(1));
    check("b1_addr",       32'(wr_addr),    32'(0));
    step(0, '0, 0, 1);
    check("b1_req_drop",   32'(wr_req),     32'(0));
    for (int i = 0; i < 4; i++) step(0, '0, 1, 0);
    check("b1_addr_next",  32'(wr_addr),    32'(4));
    check("b1_empty",      32'(fill_level), 32'(0));

    // Second burst completes the frame.
    for (int i = 5; i <= 8; i++) step(1, DATA_W'(i), 0, 0);
    idle(1);
    step(0, '0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, '0, 1, 0);
    check("frame_pulse",   32'(frame_done), 32'(1));
    check("frame_wrap",    32'(wr_addr),    32'(0));
    idle(2);
    check("frame_once",    32'(frame_cnt - fc0), 32'(1));

    // Overflow: nine words with no grant.
    do_reset();
    idle(1);
    for (int i = 0; i < 9; i++) step(1, DATA_W'(32'h100 + i), 0, 0);
    check("ovf_fill",      32'(fill_level), 32'(8));
    check("ovf_set",       32'(overflow),   32'(1));
    idle(1);
    check("ovf_after",     32'(overflow),   32'(STICKY));

    // Full FIFO with simultaneous push and pop inside a burst.
    step(0, '0, 0, 1);
    step(1, DATA_W'(32'h200), 1, 0);
    check("full_pp_fill",  32'(fill_level), 32'(8));
    check("full_pp_ovf",   32'(overflow),   32'(STICKY));
    check("full_pp_head",  32'(wr_data),    32'(32'h101));
    step(1, DATA_W'(32'h201), 1, 0);
    check("full_pp_head2", 32'(wr_data),    32'(32'h102));
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);

    // Reset in the middle of a burst.
    do_reset();
    idle(1);
    for (int i = 0; i < 4; i++) step(1, DATA_W'(32'h300 + i), 0, 0);
    idle(1);
    step(0, '0, 0, 1);
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);
    do_reset();
    idle(1);
    for (int i = 0; i < 4; i++) step(1, DATA_W'(32'h400 + i), 0, 0);
    idle(1);
    check("rb_req",        32'(wr_req),     32'(1));
    check("rb_addr",       32'(wr_addr),    32'(0));
    step(0, '0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, '0, 1, 0);
    check("rb_addr_next",  32'(wr_addr),    32'(4));

    // init_done gates new requests.
    do_reset();
    init_done = 0;
    for (int i = 0; i < 5; i++) step(1, DATA_W'(32'h500 + i), 0, 0);
    idle(3);
    check("gate_vaild",    32'(sys_vaild),  32'(0));
    check("gate_no_req",   32'(wr_req),     32'(0));
    init_done = 1;
    idle(2);
    check("gate_req",      32'(wr_req),     32'(1));
    step(0, '0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, '0, 1, 0);

    // Random traffic, including stray grants/consumes and init drops.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 149) == 0) init_done = ~init_done;
      if ($urandom_range(0, 799) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 1) == 1, DATA_W'($urandom),
             $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3);
      end
    end
    init_done = 1;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
